// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: synchronised sources, edge/level pending bits, fixed-priority claim/complete.
// Optional build macro IRQC_SLVERR_EN flags unmapped or illegal-direction accesses with pslverr.
module apb_irq_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_IRQ       = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    output logic                     pready,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pslverr,
    input  logic [NUM_IRQ-1:0]       irq_src_i,
    output logic                     irq_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] OFF_PEND     = ADDRESS_WIDTH'('h00);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_ENABLE   = ADDRESS_WIDTH'('h04);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_MODE     = ADDRESS_WIDTH'('h08);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_CLAIM    = ADDRESS_WIDTH'('h0C);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_COMPLETE = ADDRESS_WIDTH'('h10);
    localparam logic [ADDRESS_WIDTH-1:0] OFF_STATUS   = ADDRESS_WIDTH'('h14);

    logic [0:0]         state_q, state_d;
    logic               pwrite_q, pwrite_d;
    logic [NUM_IRQ-1:0] s1_q, s2_q, prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic               in_service_q, in_service_d;
    logic [4:0]         cur_id_q, cur_id_d;
    logic               irq_q, irq_d;

    logic               access, commit, acc_err, wr_en, rd_en, claim_fire;
    logic               sel_pend, sel_enable, sel_mode, sel_claim, sel_complete, sel_status;
    logic [NUM_IRQ-1:0] pe, rise, clr, claim_oh;
    logic               found;
    logic [4:0]         claim_id, claim_val;

    always_comb begin
        access       = (state_q == ACCESS);
        commit       = access && psel && penable;
        sel_pend     = (paddr == OFF_PEND);
        sel_enable   = (paddr == OFF_ENABLE);
        sel_mode     = (paddr == OFF_MODE);
        sel_claim    = (paddr == OFF_CLAIM);
        sel_complete = (paddr == OFF_COMPLETE);
        sel_status   = (paddr == OFF_STATUS);
`ifdef IRQC_SLVERR_EN
        acc_err = !(sel_pend || sel_enable || sel_mode || sel_claim || sel_complete || sel_status)
                  || (pwrite_q && (sel_claim || sel_status))
                  || (!pwrite_q && sel_complete);
        pslverr = access && acc_err;
`else
        acc_err = 1'b0;
        pslverr = 1'b0;
`endif
        wr_en  = commit && pwrite_q && !acc_err;
        rd_en  = commit && !pwrite_q && !acc_err;
        pready = access;
    end

    // Lowest index wins: only the first set bit of PEND&ENABLE is recorded.
    always_comb begin
        pe       = pend_q & enable_q;
        found    = 1'b0;
        claim_id = '0;
        claim_oh = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pe[i] && !found) begin
                found       = 1'b1;
                claim_id    = 5'(i);
                claim_oh[i] = 1'b1;
            end
        end
        claim_val  = (found && !in_service_q) ? claim_id + 5'd1 : 5'd0;
        claim_fire = rd_en && sel_claim && (claim_val != 5'd0);
    end

    always_comb begin
        prdata = '0;
        if (access && !pwrite_q && !acc_err) begin
            if (sel_pend)   prdata[NUM_IRQ-1:0] = pend_q;
            if (sel_enable) prdata[NUM_IRQ-1:0] = enable_q;
            if (sel_mode)   prdata[NUM_IRQ-1:0] = mode_q;
            if (sel_claim)  prdata[4:0]         = claim_val;
            if (sel_status) begin
                prdata[DATA_WIDTH-1] = in_service_q;
                prdata[4:0]          = cur_id_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    pwrite_d = pwrite;
                end
            end
            ACCESS: begin
                if (psel && penable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clears only touch edge-mode bits; a same-cycle edge re-sets the bit.
        rise = s2_q & ~prev_q;
        clr  = '0;
        if (wr_en && sel_pend) clr = pwdata[NUM_IRQ-1:0];
        if (claim_fire)        clr = clr | claim_oh;
        pend_d = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & s2_q);

        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr_en && sel_enable) enable_d = pwdata[NUM_IRQ-1:0];
        if (wr_en && sel_mode)   mode_d   = pwdata[NUM_IRQ-1:0];

        in_service_d = in_service_q;
        cur_id_d     = cur_id_q;
        if (claim_fire) begin
            in_service_d = 1'b1;
            cur_id_d     = claim_id;
        end else if (wr_en && sel_complete && in_service_q
                     && (pwdata == DATA_WIDTH'(cur_id_q + 5'd1))) begin
            in_service_d = 1'b0;
        end

        irq_d = (|pe) && !in_service_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            pwrite_q     <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            prev_q       <= '0;
            pend_q       <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            in_service_q <= 1'b0;
            cur_id_q     <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwrite_q     <= pwrite_d;
            s1_q         <= irq_src_i;
            s2_q         <= s1_q;
            prev_q       <= s2_q;
            pend_q       <= pend_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            in_service_q <= in_service_d;
            cur_id_q     <= cur_id_d;
            irq_q        <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule
